// File: rtl/gate_scan.sv
// Register-mapped channel gate: routes gen_in to one of N_CH PMT channels, either a
// manually selected channel or an automatic dwell-timed scan over the enabled channels.
module gate_scan #(
   parameter int          DATA_WIDTH = 8,
   parameter int          N_CH       = 10,
   parameter int unsigned BASE_ADDR  = 32'h20,
   localparam int         CH_W       = $clog2(N_CH + 1)
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  we,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic [N_CH-1:0]       keys,
   input  logic                  gen_in,
   output logic                  gen_out,
   output logic [N_CH-1:0]       ch_out,
   output logic [N_CH-1:0]       leds,
   output logic [CH_W-1:0]       sel_out,
   output logic                  busy,
   output logic                  done
);

   // Candidate and miss counters need one extra bit to represent N_CH+1.
   localparam int CW = CH_W + 1;

   localparam logic [DATA_WIDTH-1:0] A_CTRL = DATA_WIDTH'(BASE_ADDR);
   localparam logic [DATA_WIDTH-1:0] A_ERR  = DATA_WIDTH'(BASE_ADDR + 1);
   localparam logic [DATA_WIDTH-1:0] A_SEL  = DATA_WIDTH'(BASE_ADDR + 2);
   localparam logic [DATA_WIDTH-1:0] A_DLO  = DATA_WIDTH'(BASE_ADDR + 3);
   localparam logic [DATA_WIDTH-1:0] A_DHI  = DATA_WIDTH'(BASE_ADDR + 4);
   localparam logic [DATA_WIDTH-1:0] A_STAT = DATA_WIDTH'(BASE_ADDR + 5);

   typedef enum logic [1:0] {S_IDLE, S_SEEK, S_DWELL, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [CH_W-1:0]       ch_q, ch_d;
   logic [CW-1:0]         cand_q, cand_d;
   logic [CW-1:0]         miss_q, miss_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [15:0]           dwell_q, dwell_d;
   logic                  scan_q, scan_d;
   logic                  oneshot_q, oneshot_d;
   logic [3:0]            err_q, err_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
   logic [N_CH-1:0]       chOut_q, chOut_d;
   logic [N_CH-1:0]       leds_q, leds_d;
   logic                  genOut_q, genOut_d;

   logic                  wrCtrl, wrErr, wrSel, wrDlo, wrDhi, softRst;
   logic                  chInh, candInh;
   logic [3:0]            errSet, errMask;
   logic [15:0]           dwellEff;
   logic [DATA_WIDTH-1:0] rdData;

   // Channel number 0 maps to no bit; n maps to bit n-1.
   function automatic logic [N_CH-1:0] chOneHot(input logic [CW-1:0] n);
      logic [N_CH-1:0] oh;
      oh = '0;
      for (int i = 0; i < N_CH; i++) oh[i] = (n == CW'(i + 1));
      return oh;
   endfunction

   assign wrCtrl   = we && (addr == A_CTRL);
   assign wrErr    = we && (addr == A_ERR);
   assign wrSel    = we && (addr == A_SEL);
   assign wrDlo    = we && (addr == A_DLO);
   assign wrDhi    = we && (addr == A_DHI);
   assign softRst  = wrCtrl && data_in[0];
   assign chInh    = |(keys & chOneHot({1'b0, ch_q}));
   assign candInh  = |(keys & chOneHot(cand_q));
   assign dwellEff = (dwell_q == 16'd0) ? 16'd1 : dwell_q;

   // Next-state logic: FSM step first, then register writes override it,
   // and a soft reset overrides everything.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      cand_d    = cand_q;
      miss_d    = miss_q;
      cnt_d     = cnt_q;
      dwell_d   = dwell_q;
      scan_d    = scan_q;
      oneshot_d = oneshot_q;
      errSet    = '0;
      case (state_q)
         S_IDLE: begin
            if (wrSel) begin
               if (data_in > DATA_WIDTH'(N_CH)) begin
                  ch_d      = '0;
                  errSet[0] = 1'b1;
               end else if (|(keys & chOneHot(data_in[CW-1:0]))) begin
                  ch_d      = '0;
                  errSet[1] = 1'b1;
               end else begin
                  ch_d = data_in[CH_W-1:0];
               end
            end else if (chInh) begin
               ch_d      = '0;
               errSet[1] = 1'b1;
            end
         end
         S_SEEK: begin
            if (cand_q > CW'(N_CH)) begin
               if (oneshot_q) begin
                  state_d = S_DONE;
                  ch_d    = '0;
                  scan_d  = 1'b0;
               end else begin
                  cand_d = CW'(1);
               end
            end else if (candInh) begin
               cand_d = cand_q + CW'(1);
               miss_d = miss_q + CW'(1);
               if (miss_q + CW'(1) == CW'(N_CH)) begin
                  state_d   = S_IDLE;
                  ch_d      = '0;
                  scan_d    = 1'b0;
                  errSet[2] = 1'b1;
               end
            end else begin
               state_d = S_DWELL;
               ch_d    = cand_q[CH_W-1:0];
               cnt_d   = dwellEff;
               miss_d  = '0;
            end
         end
         S_DWELL: begin
            if (chInh || cnt_q <= 16'd1) begin
               state_d = S_SEEK;
               cand_d  = {1'b0, ch_q} + CW'(1);
               ch_d    = '0;
               miss_d  = '0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DONE: begin
         end
      endcase
      if (wrSel && (state_q == S_SEEK || state_q == S_DWELL)) errSet[3] = 1'b1;
      if (wrDlo) dwell_d[7:0] = data_in[7:0];
      if (wrDhi) dwell_d[15:8] = data_in[7:0];
      if (wrCtrl) begin
         scan_d    = data_in[1];
         oneshot_d = data_in[2];
         if (!data_in[1]) begin
            state_d = S_IDLE;
            ch_d    = '0;
         end else if (state_q == S_IDLE || state_q == S_DONE) begin
            state_d = S_SEEK;
            cand_d  = CW'(1);
            miss_d  = '0;
            ch_d    = '0;
         end
      end
      errMask = wrErr ? data_in[3:0] : 4'd0;
      err_d   = (err_q & ~errMask) | errSet;
      case (addr)
         A_CTRL:  rdData = DATA_WIDTH'({oneshot_q, scan_q, 1'b0});
         A_ERR:   rdData = DATA_WIDTH'(err_q);
         A_SEL:   rdData = DATA_WIDTH'(ch_q);
         A_DLO:   rdData = DATA_WIDTH'(dwell_q[7:0]);
         A_DHI:   rdData = DATA_WIDTH'(dwell_q[15:8]);
         A_STAT:  rdData = DATA_WIDTH'({done_q, busy_q});
         default: rdData = '0;
      endcase
      dataOut_d = rdData;
      leds_d    = chOneHot({1'b0, ch_q});
      chOut_d   = chOneHot({1'b0, ch_q}) & {N_CH{gen_in}};
      genOut_d  = gen_in && (ch_q != '0);
      if (softRst) begin
         state_d   = S_IDLE;
         ch_d      = '0;
         cand_d    = '0;
         miss_d    = '0;
         cnt_d     = '0;
         dwell_d   = 16'd1;
         scan_d    = 1'b0;
         oneshot_d = 1'b0;
         err_d     = '0;
         dataOut_d = '0;
         leds_d    = '0;
         chOut_d   = '0;
         genOut_d  = 1'b0;
      end
      busy_d = (state_d == S_SEEK) || (state_d == S_DWELL);
      done_d = (state_d == S_DONE);
   end

   // State and output registers, cleared asynchronously by res.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q   <= S_IDLE;
         ch_q      <= '0;
         cand_q    <= '0;
         miss_q    <= '0;
         cnt_q     <= '0;
         dwell_q   <= 16'd1;
         scan_q    <= 1'b0;
         oneshot_q <= 1'b0;
         err_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dataOut_q <= '0;
         chOut_q   <= '0;
         leds_q    <= '0;
         genOut_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         cand_q    <= cand_d;
         miss_q    <= miss_d;
         cnt_q     <= cnt_d;
         dwell_q   <= dwell_d;
         scan_q    <= scan_d;
         oneshot_q <= oneshot_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dataOut_q <= dataOut_d;
         chOut_q   <= chOut_d;
         leds_q    <= leds_d;
         genOut_q  <= genOut_d;
      end
   end

   assign data_out = dataOut_q;
   assign gen_out  = genOut_q;
   assign ch_out   = chOut_q;
   assign leds     = leds_q;
   assign sel_out  = ch_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
